p1_fetch: RTL

//  P1 instruction-fetch stage; the producer side of the P1->P2 pipeline register.

---
 rtl/p1_fetch.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/p1_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | p1_fetch : P1 instruction-fetch stage, producer side of the P1->P2 register |
// | Rev 1.0  : initial release                                                  |
// +----------------------------------------------------------------------------+

package p1_fetch_pkg;
    localparam int unsigned P1_XLEN = 32;

    typedef struct packed {
        logic [P1_XLEN-1:0] pc;
        logic [P1_XLEN-1:0] pc_plus_4;
    } p1p2_t;
endpackage

module p1_fetch
    import p1_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [31:0]     i_imem_rdata,
    output logic            o_valid,
    output logic [31:0]     o_instr,
    output p1p2_t           o_p1p2
);

    localparam int unsigned c_CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned c_SUM_W = c_CNT_W + 1;
    localparam int unsigned c_PTR_W = $clog2(DEPTH);
    localparam logic [31:0] c_NOP   = 32'h0000_0013;

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [XLEN-1:0]    r_pc;
    logic [c_CNT_W-1:0] r_outstanding;
    logic [c_CNT_W-1:0] r_kill_cnt;

    // PC FIFO: addresses of live (not killed) granted fetches, in order
    logic [XLEN-1:0]    r_pcq_mem [DEPTH];
    logic [c_PTR_W-1:0] r_pcq_wr;
    logic [c_PTR_W-1:0] r_pcq_rd;

    // Output buffer feeding the P1/P2 register
    logic [31:0]        r_ob_instr [DEPTH];
    logic [XLEN-1:0]    r_ob_pc    [DEPTH];
    logic [c_PTR_W-1:0] r_ob_wr;
    logic [c_PTR_W-1:0] r_ob_rd;
    logic [c_CNT_W-1:0] r_ob_cnt;

    logic               w_rsp;
    logic               w_pop;
    logic               w_req;
    logic               w_fire;
    logic               w_accept;
    logic               w_kill;
    logic               w_valid;
    logic [c_SUM_W-1:0] w_used;
    logic [c_CNT_W-1:0] w_out_after_rsp;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    // A response with nothing outstanding is a protocol error and is ignored
    assign w_rsp           = i_imem_rvalid & (r_outstanding != '0);
    assign w_valid         = (r_ob_cnt != '0);
    assign w_pop           = w_valid & ~i_stall;
    assign w_out_after_rsp = r_outstanding - c_CNT_W'(w_rsp);
    assign w_used          = c_SUM_W'(r_outstanding) + c_SUM_W'(r_ob_cnt) - c_SUM_W'(w_pop);

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_accept    = 1'b0;
        w_kill      = 1'b0;

        w_req = ~i_rst & ~i_redirect & (w_used < c_SUM_W'(DEPTH));

        if (!i_redirect && w_rsp) begin
            if (r_state == S_DRAIN) begin
                w_kill = 1'b1;
            end else begin
                w_accept = 1'b1;
            end
        end

        if (i_redirect) begin
            w_state_nxt = (w_out_after_rsp != '0) ? S_DRAIN : S_RUN;
        end else if ((r_state == S_DRAIN) && w_rsp && (r_kill_cnt == c_CNT_W'(1))) begin
            w_state_nxt = S_RUN;
        end
    end

    assign w_fire = w_req & i_imem_gnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_kill_cnt    <= '0;
            r_pcq_wr      <= '0;
            r_pcq_rd      <= '0;
            r_ob_wr       <= '0;
            r_ob_rd       <= '0;
            r_ob_cnt      <= '0;
        end else begin
            r_outstanding <= r_outstanding + c_CNT_W'(w_fire) - c_CNT_W'(w_rsp);
            if (i_redirect) begin
                r_pc       <= i_redirect_pc & ~XLEN'(3);
                r_kill_cnt <= w_out_after_rsp;
                r_pcq_wr   <= '0;
                r_pcq_rd   <= '0;
                r_ob_wr    <= '0;
                r_ob_rd    <= '0;
                r_ob_cnt   <= '0;
            end else begin
                if (w_fire) begin
                    r_pc     <= r_pc + XLEN'(4);
                    r_pcq_wr <= ptr_inc(r_pcq_wr);
                end
                if (w_kill) begin
                    r_kill_cnt <= r_kill_cnt - c_CNT_W'(1);
                end
                if (w_accept) begin
                    r_pcq_rd <= ptr_inc(r_pcq_rd);
                    r_ob_wr  <= ptr_inc(r_ob_wr);
                end
                if (w_pop) begin
                    r_ob_rd <= ptr_inc(r_ob_rd);
                end
                r_ob_cnt <= r_ob_cnt + c_CNT_W'(w_accept) - c_CNT_W'(w_pop);
            end
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers above
    always_ff @(posedge i_clk) begin
        if (w_fire) begin
            r_pcq_mem[r_pcq_wr] <= r_pc;
        end
        if (w_accept) begin
            r_ob_instr[r_ob_wr] <= i_imem_rdata;
            r_ob_pc[r_ob_wr]    <= r_pcq_mem[r_pcq_rd];
        end
    end

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_pc;
    assign o_valid     = w_valid;

    always_comb begin
        o_instr = c_NOP;
        o_p1p2  = '0;
        if (w_valid) begin
            o_instr          = r_ob_instr[r_ob_rd];
            o_p1p2.pc        = r_ob_pc[r_ob_rd];
            o_p1p2.pc_plus_4 = r_ob_pc[r_ob_rd] + XLEN'(4);
        end
    end

endmodule

`default_nettype wire
